// File: rtl/vector_mem_arbiter_pkg.sv
// Shared vector memory types: the request/response record, access-type codes
// and the round-robin search helper used by the request arbiter.
package vector_mem_arbiter_pkg;

  localparam int REQUEST_COUNTER_WIDTH = 4;
  localparam int ADDR_WIDTH            = 32;
  localparam int DATA_WIDTH            = 32;
  localparam int CORE_ID_WIDTH         = 8;

  // rr_pick searches a fixed-width mask; unused upper bits must be zero.
  localparam int RR_MAX_PORTS = 32;
  localparam int RR_IDX_WIDTH = 5;

  typedef enum logic [1:0] {
    ACCESS_LOAD          = 2'd0,
    ACCESS_STORE         = 2'd1,
    ACCESS_LOAD_STRIDED  = 2'd2,
    ACCESS_STORE_STRIDED = 2'd3
  } access_type_e;

  typedef struct packed {
    logic                             vld;
    logic [CORE_ID_WIDTH-1:0]         core_id;
    access_type_e                     access_type;
    logic [REQUEST_COUNTER_WIDTH-1:0] access_length;
    logic [ADDR_WIDTH-1:0]            addr;
    logic [DATA_WIDTH-1:0]            data;
  } request_t;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                    found;
    logic [RR_IDX_WIDTH-1:0] idx;
  } rr_pick_t;

  // First set bit of mask at or after ptr, wrapping; scanned from the far end
  // so the nearest candidate is the last one written.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_PORTS-1:0] mask,
                                       input logic [RR_IDX_WIDTH-1:0] ptr);
    rr_pick_t                res;
    logic [RR_IDX_WIDTH-1:0] cand;
    res = '0;
    for (int k = RR_MAX_PORTS - 1; k >= 0; k--) begin
      cand = ptr + RR_IDX_WIDTH'(k);
      if (mask[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/vector_rr_arbiter.sv
// Combinational round-robin picker: one-hot grant to the first requester at
// or after ptr_i. Supports up to RR_MAX_PORTS requesters.
import vector_mem_arbiter_pkg::*;

module vector_rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int PTR_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [PTR_W-1:0]     ptr_i,
  output logic [NUM_PORTS-1:0] grant_o,
  output logic                 found_o,
  output logic [PTR_W-1:0]     idx_o
);

  rr_pick_t pick;

  always_comb begin
    pick    = rr_pick(RR_MAX_PORTS'(req_i), RR_IDX_WIDTH'(ptr_i));
    found_o = pick.found;
    idx_o   = PTR_W'(pick.idx);
  end

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_grant
    assign grant_o[gi] = pick.found && (pick.idx == RR_IDX_WIDTH'(gi));
  end

endmodule

// File: rtl/vector_mem_arbiter.sv
// Shares one memory request port among NUM_PORTS vector LSUs with burst-locked
// round-robin arbitration, and routes memory responses back by core_id.
import vector_mem_arbiter_pkg::*;

module vector_mem_arbiter #(
  parameter int NUM_PORTS    = 4,
  parameter int BASE_CORE_ID = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  request_t             lsu_req [NUM_PORTS],
  output logic [NUM_PORTS-1:0] lsu_grant,
  output request_t             lsu_rsp [NUM_PORTS],
  output request_t             mem_req,
  input  logic                 mem_grant,
  input  request_t             mem_rsp,
  output logic                 misroute_err
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int BW = REQUEST_COUNTER_WIDTH + 1;

  arb_state_e     state_q, state_d;
  logic [PW-1:0]  own_q, own_d;
  logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]  beats_q, beats_d;
  logic [BW-1:0]  len_q, len_d;
  request_t       mem_req_q, mem_req_d;
  logic           misroute_q, misroute_d;
  request_t       rsp_q [NUM_PORTS];
  request_t       rsp_d [NUM_PORTS];

  logic [NUM_PORTS-1:0] req_mask;
  logic [NUM_PORTS-1:0] pick_onehot;
  logic                 pick_found;
  logic [PW-1:0]        pick_idx;
  logic                 slot_free;
  logic [BW-1:0]        first_len;
  logic [BW-1:0]        beats_inc;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(NUM_PORTS - 1)) ? '0 : p + 1'b1;
  endfunction

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_mask
    assign req_mask[gi] = lsu_req[gi].vld;
  end

  vector_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PW)
  ) u_rr (
    .req_i   (req_mask),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_onehot),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    slot_free = !mem_req_q.vld || mem_grant;
    lsu_grant = '0;
    state_d   = state_q;
    own_d     = own_q;
    rr_ptr_d  = rr_ptr_q;
    beats_d   = beats_q;
    len_d     = len_q;
    mem_req_d = mem_req_q;
    if (mem_grant) mem_req_d.vld = 1'b0;
    // A zero access_length is treated as a single-beat access.
    first_len = (lsu_req[pick_idx].access_length == '0) ? BW'(1)
                                                         : BW'(lsu_req[pick_idx].access_length);
    beats_inc = beats_q + BW'(1);

    unique case (state_q)
      ARB_IDLE: begin
        if (!reset && slot_free && pick_found) begin
          lsu_grant = pick_onehot;
          mem_req_d = lsu_req[pick_idx];
          own_d     = pick_idx;
          len_d     = first_len;
          beats_d   = BW'(1);
          if (first_len == BW'(1)) rr_ptr_d = wrap_inc(pick_idx);
          else                     state_d  = ARB_BURST;
        end
      end
      ARB_BURST: begin
        // Lock is held through owner idle cycles until the last beat goes out.
        if (!reset && slot_free && lsu_req[own_q].vld) begin
          lsu_grant[own_q] = 1'b1;
          mem_req_d        = lsu_req[own_q];
          beats_d          = beats_inc;
          if (beats_inc == len_q) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = wrap_inc(own_q);
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      own_q      <= '0;
      rr_ptr_q   <= '0;
      beats_q    <= '0;
      len_q      <= '0;
      mem_req_q  <= '0;
      misroute_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      own_q      <= own_d;
      rr_ptr_q   <= rr_ptr_d;
      beats_q    <= beats_d;
      len_q      <= len_d;
      mem_req_q  <= mem_req_d;
      misroute_q <= misroute_d;
    end
  end

  // Offset wraps on underflow, so core_ids below the base also fail the range test.
  logic [CORE_ID_WIDTH-1:0] rsp_off;
  logic                     rsp_in_range;

  assign rsp_off      = mem_rsp.core_id - CORE_ID_WIDTH'(BASE_CORE_ID);
  assign rsp_in_range = rsp_off < CORE_ID_WIDTH'(NUM_PORTS);
  assign misroute_d   = misroute_q | (mem_rsp.vld && !rsp_in_range);

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_rsp
    assign rsp_d[gi] = (mem_rsp.vld && rsp_in_range && rsp_off == CORE_ID_WIDTH'(gi))
                       ? mem_rsp : '0;

    always_ff @(posedge clk) begin
      if (reset) rsp_q[gi] <= '0;
      else       rsp_q[gi] <= rsp_d[gi];
    end

    assign lsu_rsp[gi] = rsp_q[gi];
  end

  assign mem_req      = mem_req_q;
  assign misroute_err = misroute_q;

endmodule
